// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Counter must be able to hold WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor, Diff = A - B - Bin, LSB first over WIDTH cycles.
// Optional signed-overflow output Ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_r;
    state_e             state_s;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   diff_r;
    logic               borrow_r;
    logic               bout_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               d_s;
    logic               bout_s;
    logic               last_s;
`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb_r;
    logic               b_msb_r;
    logic               ovf_r;
`endif

    full_subtractor u_cell (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .bin  (borrow_r),
        .d    (d_s),
        .bout (bout_s)
    );

    assign last_s = (state_r == RUN) && (cnt_r == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Operand capture, one subtract step per RUN cycle, result latch on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            diff_r   <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
            bout_r   <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r  <= 1'b0;
            b_msb_r  <= 1'b0;
            ovf_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r   <= A;
                        b_sh_r   <= B;
                        borrow_r <= Bin;
                        cnt_r    <= {CNT_W{1'b0}};
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_r  <= A[WIDTH-1];
                        b_msb_r  <= B[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    diff_r   <= {d_s, diff_r[WIDTH-1:1]};
                    borrow_r <= bout_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        bout_r <= bout_s;
`ifdef SERIAL_SUB_OVF_EN
                        // d_s is the final MSB of Diff on this step
                        ovf_r  <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
`endif
                    end
                end
                default: begin
                    diff_r <= diff_r;
                end
            endcase
        end
    end

    assign Diff = diff_r;
    assign Bout = bout_r;
`ifdef SERIAL_SUB_OVF_EN
    assign Ovf  = ovf_r;
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial ripple-borrow subtractor computing Diff = A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell. Sits alongside the combinational ripple-carry adder as its inverse-direction arithmetic unit. It is intended for area-constrained datapaths that can tolerate WIDTH-cycle latency. Operands enter and results leave through valid/ready handshakes.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands A/B/Bin valid
- in_ready  output  1  block can accept operands
- A  input  WIDTH  minuend, unsigned
- B  input  WIDTH  subtrahend, unsigned
- Bin  input  1  borrow-in
- out_valid  output  1  Diff/Bout valid
- out_ready  input  1  consumer accepts result
- Diff  output  WIDTH  A − B − Bin modulo 2^WIDTH
- Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned)
- Ovf  output  1  signed overflow (only with SERIAL_SUB_OVF_EN)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1, out_valid=0. When in_valid && in_ready at a clock edge: capture A, B into shift registers, load borrow from Bin, clear bit counter, go to RUN.
- RUN: in_ready=0. Each cycle, apply the full-subtractor to LSBs a, b and borrow:
  - d = a^b^borrow
  - borrow' = (~a&b) | (~(a^b)&borrow)
  - Shift d into Diff from the MSB side; shift A and B right; increment the counter.
  - After the WIDTH-th bit, load Bout from the final borrow and go to DONE.
- DONE: out_valid=1. Diff, Bout and Ovf are held stable until out_valid && out_ready at an edge, then go to IDLE.
- in_valid while not in IDLE: ignored, with no capture and no side effect.
- Diff is meaningful only while out_valid=1. Its contents during RUN are unspecified.
- Counter width: $clog2(WIDTH+1). It never wraps past WIDTH.

## Timing
- Reset values (async assert, sync deassert by system): state=IDLE, in_ready=1 (inputs ignored while rst_n=0), out_valid=0, Diff=0, Bout=0, Ovf=0, counter=0.
- Latency: operands accepted at edge k; out_valid rises after edge k+WIDTH.
- Minimum initiation interval: WIDTH+2 cycles (RUN ×WIDTH, DONE ≥1, IDLE 1). There is no back-to-back acceptance in DONE.
- out_valid, once asserted, stays high with stable outputs until the handshake completes.
- in_ready is a registered-state decode (state==IDLE). There is no combinational path from out_ready to in_ready.
- rst_n asserted in any state aborts the operation immediately. The partial result is discarded and no out_valid pulse occurs.
- Simultaneous in_valid and out_ready in DONE: only the result handshake completes; the operand is taken in the next IDLE cycle.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - The Ovf port exists.
  - Ovf = (A[W-1]≠B[W-1]) && (Diff[W-1]≠A[W-1]), registered at the RUN→DONE transition from the captured sign bits.
  - Ovf is held with Diff.
- SERIAL_SUB_OVF_EN undefined: the Ovf port and its sign-bit registers are absent, and there is no other behavioural change.

## Structure
- Shared package serial_sub_pkg contains:
  - state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10
  - counter-width constant/function
- Sub-module full_subtractor: combinational 1-bit cell with inputs a, b, bin and outputs d, bout. It is instantiated once and reused every RUN cycle.

## Test plan
- WIDTH=4, A=7, B=5, Bin=0 → Diff=2, Bout=0; out_valid rises exactly 4 cycles after acceptance.
- A=3, B=5, Bin=0 → Diff=4'b1110, Bout=1. Then A=0, B=0, Bin=1 → Diff=4'b1111, Bout=1.
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with A=1, B=1:
  - out_valid, Diff and Bout stay stable and in_ready stays 0.
  - After out_ready=1, one IDLE cycle follows, then the new operand is accepted.
- Assert rst_n=0 during the 2nd RUN cycle → out_valid=0, Diff=0, in_ready=1 after release. A subsequent A=9, B=4 → Diff=5, Bout=0.
- Exhaustive sweep of all A, B and Bin values for WIDTH=4 with random out_ready stalls → every result matches the (A−B−Bin) mod 16 reference, and Bout matches the unsigned compare.
- With SERIAL_SUB_OVF_EN: A=4'b0111, B=4'b1000 → Diff=4'b1111, Bout=1, Ovf=1. A=2, B=1 → Diff=1, Ovf=0.
